// File: rtl/div_monitor.sv
// Measures the half-period of an unrelated toggling signal (e.g. a divided clock)
// in clk cycles, and flags lock stability and stalls.
module div_monitor (
    input  logic        clk,
    input  logic        rst,
    input  logic        sig_in,
    input  logic [31:0] timeout,
    output logic        edge_tick,
    output logic        rise_tick,
    output logic [31:0] half_period,
    output logic        valid,
    output logic        stable,
    output logic        stalled,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2,
        STALL  = 2'd3
    } state_t;

    state_t      state;
    logic        s1, s2, s3;
    logic [31:0] cnt;
    logic        det_edge;
    logic        det_rise;
    logic        timed_out;

    assign det_edge  = s2 ^ s3;
    assign det_rise  = s2 & ~s3;
    // >= so that lowering timeout below the running count still trips a stall
    assign timed_out = (timeout != 32'd0) && (cnt >= timeout);
    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            cnt         <= 32'd0;
            state       <= IDLE;
            edge_tick   <= 1'b0;
            rise_tick   <= 1'b0;
            half_period <= 32'd0;
            valid       <= 1'b0;
            stable      <= 1'b0;
            stalled     <= 1'b0;
        end else begin
            s1        <= sig_in;
            s2        <= s1;
            s3        <= s2;
            edge_tick <= det_edge;
            rise_tick <= det_rise;

            if (det_edge) begin
                cnt <= 32'd0;
            end else if (cnt != 32'hFFFF_FFFF) begin
                cnt <= cnt + 32'd1;
            end

            // An edge always takes priority over a coincident timeout.
            case (state)
                IDLE: begin
                    if (det_edge) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (det_edge) begin
                        half_period <= cnt;
                        valid       <= 1'b1;
                        state       <= LOCKED;
                    end else if (timed_out) begin
                        state   <= STALL;
                        stalled <= 1'b1;
                        valid   <= 1'b0;
                        stable  <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (det_edge) begin
                        half_period <= cnt;
                        stable      <= (cnt == half_period);
                    end else if (timed_out) begin
                        state   <= STALL;
                        stalled <= 1'b1;
                        valid   <= 1'b0;
                        stable  <= 1'b0;
                    end
                end
                STALL: begin
                    if (det_edge) begin
                        state   <= ARMED;
                        stalled <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_monitor.sv
// Self-checking bench for div_monitor: edge pulses, lock, stability, stall and reset behaviour.
module tb_div_monitor;

    logic        clk;
    logic        rst;
    logic        sig_in;
    logic [31:0] timeout;
    logic        edge_tick;
    logic        rise_tick;
    logic [31:0] half_period;
    logic        valid;
    logic        stable;
    logic        stalled;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];

    // Observations gathered by the watch task over one toggle interval.
    int          tick_cnt;
    int          tick_at;
    logic        seen_rise;
    logic [31:0] tick_hp;
    logic        tick_valid;
    logic        tick_stable;
    logic [1:0]  tick_state;
    logic        any_stall;

    div_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .sig_in      (sig_in),
        .timeout     (timeout),
        .edge_tick   (edge_tick),
        .rise_tick   (rise_tick),
        .half_period (half_period),
        .valid       (valid),
        .stable      (stable),
        .stalled     (stalled),
        .fsm_state   (fsm_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    task automatic watch(input int p);
        tick_cnt  = 0;
        tick_at   = -1;
        seen_rise = 1'b0;
        any_stall = 1'b0;
        for (int i = 0; i < p; i++) begin
            sample();
            if (stalled) any_stall = 1'b1;
            if (edge_tick) begin
                tick_cnt++;
                tick_at     = i;
                if (rise_tick) seen_rise = 1'b1;
                tick_hp     = half_period;
                tick_valid  = valid;
                tick_stable = stable;
                tick_state  = fsm_state;
            end
        end
    endtask

    task automatic toggle_and_watch(input int p);
        @(negedge clk);
        sig_in = ~sig_in;
        watch(p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Pops the scoreboard and compares it with the half_period seen at the last tick.
    task automatic pop_hp(input string name);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got half_period=%0d", name, tick_hp);
        end else begin
            e = exp_q.pop_front();
            if (tick_hp !== e) begin
                errors++;
                $display("FAIL %s: half_period got %0d expected %0d", name, tick_hp, e);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst     = 1'b1;
        sig_in  = 1'b1;
        timeout = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({edge_tick, rise_tick, half_period, valid, stable, stalled, fsm_state} !== 38'd0) begin
            errors++;
            $display("FAIL reset_outputs: got hp=%0d v=%0b s=%0b st=%0b fsm=%0d expected all 0",
                     half_period, valid, stable, stalled, fsm_state);
        end
        rst = 1'b0;
        watch(10);
        checks++;
        if (tick_cnt !== 1 || seen_rise !== 1'b1 || tick_state !== 2'd1 || tick_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_rise: ticks=%0d rise=%0b fsm=%0d valid=%0b expected 1,1,1,0",
                     tick_cnt, seen_rise, tick_state, tick_valid);
        end
    endtask

    task automatic test_lock();
        do_reset();
        timeout = 32'd0;
        toggle_and_watch(10);
        checks++;
        if (tick_cnt !== 1 || tick_at !== 2 || seen_rise !== 1'b1) begin
            errors++;
            $display("FAIL lock_first_edge: ticks=%0d offset=%0d rise=%0b expected 1,2,1",
                     tick_cnt, tick_at, seen_rise);
        end
        checks++;
        if (tick_valid !== 1'b0 || tick_state !== 2'd1) begin
            errors++;
            $display("FAIL lock_armed: valid=%0b fsm=%0d expected 0,1", tick_valid, tick_state);
        end
        exp_q.push_back(32'd9);
        toggle_and_watch(10);
        checks++;
        if (tick_cnt !== 1 || seen_rise !== 1'b0 || tick_valid !== 1'b1 || tick_stable !== 1'b0) begin
            errors++;
            $display("FAIL lock_second_edge: ticks=%0d rise=%0b valid=%0b stable=%0b expected 1,0,1,0",
                     tick_cnt, seen_rise, tick_valid, tick_stable);
        end
        pop_hp("lock_hp2");
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(32'd9);
            toggle_and_watch(10);
            checks++;
            if (tick_cnt !== 1 || tick_valid !== 1'b1 || tick_stable !== 1'b1 || tick_state !== 2'd2) begin
                errors++;
                $display("FAIL lock_steady: ticks=%0d valid=%0b stable=%0b fsm=%0d expected 1,1,1,2",
                         tick_cnt, tick_valid, tick_stable, tick_state);
            end
            pop_hp("lock_hp_steady");
        end
        // Stop toggling while locked: stall must drop valid/stable but keep half_period.
        @(negedge clk);
        timeout = 32'd30;
        watch(40);
        checks++;
        if (stalled !== 1'b1 || valid !== 1'b0 || stable !== 1'b0 || half_period !== 32'd9 || fsm_state !== 2'd3) begin
            errors++;
            $display("FAIL locked_stall: st=%0b v=%0b s=%0b hp=%0d fsm=%0d expected 1,0,0,9,3",
                     stalled, valid, stable, half_period, fsm_state);
        end
    endtask

    task automatic test_stall();
        int t_tick;
        int t_fall;
        int t_stall;
        do_reset();
        timeout = 32'd50;
        @(negedge clk);
        sig_in  = 1'b1;
        t_tick  = -1;
        t_fall  = -1;
        t_stall = -1;
        for (int i = 0; i < 100; i++) begin
            sample();
            if (edge_tick && t_tick < 0) t_tick = i;
            if (!edge_tick && t_tick >= 0 && t_fall < 0) t_fall = i;
            if (stalled && t_stall < 0) begin
                t_stall = i;
                checks++;
                if (valid !== 1'b0 || fsm_state !== 2'd3) begin
                    errors++;
                    $display("FAIL stall_flags: valid=%0b fsm=%0d expected 0,3", valid, fsm_state);
                end
            end
        end
        checks++;
        if (t_tick !== 2 || t_stall < 0 || (t_stall - t_fall) !== 50) begin
            errors++;
            $display("FAIL stall_timing: tick=%0d fall=%0d stall=%0d expected tick 2, stall 50 after fall",
                     t_tick, t_fall, t_stall);
        end
        toggle_and_watch(10);
        checks++;
        if (tick_cnt !== 1 || tick_state !== 2'd1 || stalled !== 1'b0) begin
            errors++;
            $display("FAIL stall_recover: ticks=%0d fsm=%0d stalled=%0b expected 1,1,0",
                     tick_cnt, tick_state, stalled);
        end
        @(negedge clk);
        timeout = 32'd0;
        watch(20);
        @(negedge clk);
        timeout = 32'd5;
        sample();
        checks++;
        if (stalled !== 1'b1) begin
            errors++;
            $display("FAIL timeout_change: stalled got %0b expected 1", stalled);
        end
    endtask

    task automatic test_period_change();
        do_reset();
        timeout = 32'd0;
        for (int k = 0; k < 3; k++) toggle_and_watch(10);
        // First P=6 toggle still closes a 10-cycle interval.
        exp_q.push_back(32'd9);
        toggle_and_watch(6);
        pop_hp("pchg_hp_a");
        checks++;
        if (tick_stable !== 1'b1) begin
            errors++;
            $display("FAIL pchg_stable_a: got %0b expected 1", tick_stable);
        end
        exp_q.push_back(32'd5);
        toggle_and_watch(6);
        pop_hp("pchg_hp_b");
        checks++;
        if (tick_stable !== 1'b0 || tick_valid !== 1'b1) begin
            errors++;
            $display("FAIL pchg_stable_b: stable=%0b valid=%0b expected 0,1", tick_stable, tick_valid);
        end
        exp_q.push_back(32'd5);
        toggle_and_watch(6);
        pop_hp("pchg_hp_c");
        checks++;
        if (tick_stable !== 1'b1) begin
            errors++;
            $display("FAIL pchg_stable_c: got %0b expected 1", tick_stable);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        timeout = 32'd0;
        for (int k = 0; k < 3; k++) toggle_and_watch(10);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({edge_tick, rise_tick, half_period, valid, stable, stalled, fsm_state} !== 38'd0) begin
            errors++;
            $display("FAIL reset_mid_async: hp=%0d v=%0b s=%0b st=%0b fsm=%0d expected all 0",
                     half_period, valid, stable, stalled, fsm_state);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        watch(10);
        checks++;
        if (tick_cnt !== 1 || seen_rise !== 1'b1 || tick_valid !== 1'b0 || tick_state !== 2'd1) begin
            errors++;
            $display("FAIL reset_mid_rise: ticks=%0d rise=%0b valid=%0b fsm=%0d expected 1,1,0,1",
                     tick_cnt, seen_rise, tick_valid, tick_state);
        end
        exp_q.push_back(32'd9);
        toggle_and_watch(10);
        checks++;
        if (tick_valid !== 1'b1 || tick_stable !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_relock: valid=%0b stable=%0b expected 1,0", tick_valid, tick_stable);
        end
        pop_hp("reset_mid_hp");
    endtask

    task automatic test_coincide();
        logic stall_seen;
        do_reset();
        timeout    = 32'd10;
        stall_seen = 1'b0;
        toggle_and_watch(11);
        if (any_stall) stall_seen = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(32'd10);
            toggle_and_watch(11);
            if (any_stall) stall_seen = 1'b1;
            pop_hp("coincide_hp");
        end
        checks++;
        if (stall_seen !== 1'b0 || valid !== 1'b1) begin
            errors++;
            $display("FAIL coincide_no_stall: stall_seen=%0b valid=%0b expected 0,1", stall_seen, valid);
        end
    endtask

    task automatic test_divider();
        int div_cnt;
        int toggles;
        int pops;
        do_reset();
        timeout = 32'd0;
        div_cnt = 0;
        toggles = 0;
        pops    = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (div_cnt == 3) begin
                div_cnt = 0;
                sig_in  = ~sig_in;
                toggles++;
                if (toggles >= 2) exp_q.push_back(32'd3);
            end else begin
                div_cnt++;
            end
            sample();
            if (edge_tick && valid) begin
                tick_hp = half_period;
                pop_hp("divider_hp");
                pops++;
            end
        end
        checks++;
        if (half_period !== 32'd3 || valid !== 1'b1 || stable !== 1'b1 || pops < 10) begin
            errors++;
            $display("FAIL divider_final: hp=%0d v=%0b s=%0b pops=%0d expected 3,1,1,>=10",
                     half_period, valid, stable, pops);
        end
        exp_q.delete();
    endtask

    initial begin
        rst     = 1'b1;
        sig_in  = 1'b0;
        timeout = 32'd0;
        test_reset();
        test_lock();
        test_stall();
        test_period_change();
        test_reset_mid();
        test_coincide();
        test_divider();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
